// File: rtl/regfile_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : regfile_wb_sequencer
// Brief   : In-order writeback queue that issues one register-file write per
//           cycle and exports a pending-write scoreboard. Define WB_BYPASS_EN
//           to enable forwarding of queued results to the decode selects.
// Revision: 1.0
// ============================================================================
module regfile_wb_sequencer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32
) (
  input  logic                  Clk,
  input  logic                  RESET,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [3:0]            req_dest,
  input  logic                  req_src,
  input  logic [DATA_W-1:0]     req_data,
  input  logic [11:0]           rd_sel,
  input  logic                  rf_stall,
  input  logic                  flush,
  output logic [DATA_W-1:0]     rf_Rd,
  output logic [DATA_W-1:0]     rf_Mem,
  output logic [DATA_W-1:0]     rf_Pcin,
  output logic                  rf_LOAD,
  output logic                  rf_LOADPC,
  output logic                  rf_IR_CU,
  output logic [19:0]           rf_RSLCT,
  output logic [15:0]           pend_mask,
  output logic [3:0]            q_count,
  output logic [2:0]            fwd_hit,
  output logic [3*DATA_W-1:0]   fwd_data
);

  localparam int         PTR_W    = $clog2(DEPTH);
  localparam logic [3:0] C_DEPTH  = 4'(DEPTH);
  localparam logic [3:0] C_PC_REG = 4'd15;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  logic [3:0]        dest_mem [DEPTH];
  logic              src_mem  [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [3:0]        count_q, count_d;
  logic              ready_q, ready_d;
  state_t            state_q;

  logic [DATA_W-1:0] rd_q, mem_q, pcin_q;
  logic              load_q, loadpc_q, ircu_q;
  logic [3:0]        rslct_q;

  logic              do_push, do_pop;
  logic [3:0]        head_dest;
  logic              head_src;
  logic [DATA_W-1:0] head_data;

  assign head_dest = dest_mem[rd_ptr_q];
  assign head_src  = src_mem[rd_ptr_q];
  assign head_data = data_mem[rd_ptr_q];

  // Flush wins over both push and pop; a request on a flush edge is dropped.
  always_comb begin
    do_push = req_valid & ready_q & ~flush;
    do_pop  = (count_q != 4'd0) & ~rf_stall & ~flush;
    if (flush)
      count_d = 4'd0;
    else
      count_d = count_q + {3'b000, do_push} - {3'b000, do_pop};
    ready_d = (count_d < C_DEPTH);
  end

  always_ff @(posedge Clk) begin
    if (do_push) begin
      dest_mem[wr_ptr_q] <= req_dest;
      src_mem[wr_ptr_q]  <= req_src;
      data_mem[wr_ptr_q] <= req_data;
    end
  end

  always_ff @(posedge Clk or negedge RESET) begin
    if (!RESET) begin
      state_q  <= S_IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= 4'd0;
      ready_q  <= 1'b0;
      rd_q     <= '0;
      mem_q    <= '0;
      pcin_q   <= '0;
      load_q   <= 1'b0;
      loadpc_q <= 1'b0;
      ircu_q   <= 1'b0;
      rslct_q  <= 4'd0;
    end else begin
      count_q <= count_d;
      ready_q <= ready_d;
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end

      rd_q     <= '0;
      mem_q    <= '0;
      pcin_q   <= '0;
      load_q   <= 1'b0;
      loadpc_q <= 1'b0;
      ircu_q   <= 1'b0;
      rslct_q  <= 4'd0;

      if (do_pop) begin
        state_q <= S_ISSUE;
        ircu_q  <= 1'b1;
        rslct_q <= head_dest;
        if (head_dest == C_PC_REG) begin
          pcin_q   <= head_data;
          loadpc_q <= 1'b1;
        end else if (head_src) begin
          mem_q  <= head_data;
          load_q <= 1'b1;
        end else begin
          rd_q   <= head_data;
          load_q <= 1'b1;
        end
      end else if ((count_q != 4'd0) && !flush) begin
        state_q <= S_HOLD;
      end else begin
        state_q <= S_IDLE;
      end
    end
  end

  assign req_ready = ready_q;
  assign rf_Rd     = rd_q;
  assign rf_Mem    = mem_q;
  assign rf_Pcin   = pcin_q;
  assign rf_LOAD   = load_q;
  assign rf_LOADPC = loadpc_q;
  assign rf_IR_CU  = ircu_q;
  assign rf_RSLCT  = {4'b0000, rd_sel, rslct_q};
  assign q_count   = count_q;

  // The issue stage's dest lives in rslct_q while a write is on the bus.
  always_comb begin
    pend_mask = '0;
    if (state_q == S_ISSUE)
      pend_mask[rslct_q] = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      if (4'(k) < count_q)
        pend_mask[dest_mem[rd_ptr_q + PTR_W'(k)]] = 1'b1;
    end
  end

`ifdef WB_BYPASS_EN
  for (genvar f = 0; f < 3; f++) begin : g_fwd
    logic [3:0]        fld_sel;
    logic              fld_hit;
    logic [DATA_W-1:0] fld_data;

    assign fld_sel = rd_sel[4*f +: 4];

    // Scan oldest to youngest so the last match left standing is the youngest.
    always_comb begin
      fld_hit  = 1'b0;
      fld_data = '0;
      if ((state_q == S_ISSUE) && (rslct_q != C_PC_REG) && (rslct_q == fld_sel)) begin
        fld_hit  = 1'b1;
        fld_data = rd_q | mem_q;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((4'(k) < count_q) &&
            (dest_mem[rd_ptr_q + PTR_W'(k)] != C_PC_REG) &&
            (dest_mem[rd_ptr_q + PTR_W'(k)] == fld_sel)) begin
          fld_hit  = 1'b1;
          fld_data = data_mem[rd_ptr_q + PTR_W'(k)];
        end
      end
    end

    assign fwd_hit[f]                  = fld_hit;
    assign fwd_data[f*DATA_W +: DATA_W] = fld_data;
  end
`else
  assign fwd_hit  = '0;
  assign fwd_data = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_regfile_wb_sequencer
// Brief   : Directed vector table plus hand sequences for reset, flush and
//           forwarding behaviour of regfile_wb_sequencer.
// Revision: 1.0
// ============================================================================
module tb_regfile_wb_sequencer;

  localparam int DATA_W = 32;
`ifdef WB_BYPASS_EN
  localparam logic C_BYP = 1'b1;
`else
  localparam logic C_BYP = 1'b0;
`endif

  logic                Clk;
  logic                RESET;
  logic                req_valid;
  logic                req_ready;
  logic [3:0]          req_dest;
  logic                req_src;
  logic [DATA_W-1:0]   req_data;
  logic [11:0]         rd_sel;
  logic                rf_stall;
  logic                flush;
  logic [DATA_W-1:0]   rf_Rd, rf_Mem, rf_Pcin;
  logic                rf_LOAD, rf_LOADPC, rf_IR_CU;
  logic [19:0]         rf_RSLCT;
  logic [15:0]         pend_mask;
  logic [3:0]          q_count;
  logic [2:0]          fwd_hit;
  logic [3*DATA_W-1:0] fwd_data;

  int n_checks = 0;
  int n_errors = 0;

  regfile_wb_sequencer #(.DEPTH(4), .DATA_W(DATA_W)) dut (
    .Clk(Clk), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_dest(req_dest),
    .req_src(req_src), .req_data(req_data), .rd_sel(rd_sel),
    .rf_stall(rf_stall), .flush(flush),
    .rf_Rd(rf_Rd), .rf_Mem(rf_Mem), .rf_Pcin(rf_Pcin),
    .rf_LOAD(rf_LOAD), .rf_LOADPC(rf_LOADPC), .rf_IR_CU(rf_IR_CU),
    .rf_RSLCT(rf_RSLCT), .pend_mask(pend_mask), .q_count(q_count),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic        v;
    logic [3:0]  dest;
    logic        src;
    logic [31:0] data;
    logic        stall;
    logic        ld;
    logic        lpc;
    logic [3:0]  rsl;
    logic [31:0] rd;
    logic [31:0] mem;
    logic [31:0] pc;
    logic [15:0] pend;
    logic [3:0]  qc;
    logic        rdy;
  } vec_t;

  vec_t vt[20];

  function automatic vec_t mk(logic v, logic [3:0] dest, logic src, logic [31:0] data,
                              logic stall, logic ld, logic lpc, logic [3:0] rsl,
                              logic [31:0] rd, logic [31:0] mem, logic [31:0] pc,
                              logic [15:0] pend, logic [3:0] qc, logic rdy);
    vec_t r;
    r.v = v; r.dest = dest; r.src = src; r.data = data; r.stall = stall;
    r.ld = ld; r.lpc = lpc; r.rsl = rsl; r.rd = rd; r.mem = mem; r.pc = pc;
    r.pend = pend; r.qc = qc; r.rdy = rdy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic s,
                       input logic [31:0] dat, input logic st, input logic fl);
    req_valid = v; req_dest = d; req_src = s; req_data = dat;
    rf_stall = st; flush = fl;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // v dest src data stall | ld lpc rsl rd mem pc pend qc rdy
    vt[0]  = mk(1, 4'd2,  0, 32'h1,  0, 0, 0, 4'd0,  32'h0,  32'h0, 32'h0,  16'h0004, 4'd1, 1);
    vt[1]  = mk(0, 4'd0,  0, 32'h0,  0, 1, 0, 4'd2,  32'h1,  32'h0, 32'h0,  16'h0004, 4'd0, 1);
    vt[2]  = mk(1, 4'd15, 0, 32'h40, 0, 0, 0, 4'd0,  32'h0,  32'h0, 32'h0,  16'h8000, 4'd1, 1);
    vt[3]  = mk(1, 4'd3,  1, 32'h7,  0, 0, 1, 4'd15, 32'h0,  32'h0, 32'h40, 16'h8008, 4'd1, 1);
    vt[4]  = mk(0, 4'd0,  0, 32'h0,  0, 1, 0, 4'd3,  32'h0,  32'h7, 32'h0,  16'h0008, 4'd0, 1);
    vt[5]  = mk(0, 4'd0,  0, 32'h0,  0, 0, 0, 4'd0,  32'h0,  32'h0, 32'h0,  16'h0000, 4'd0, 1);
    vt[6]  = mk(1, 4'd1,  0, 32'h11, 1, 0, 0, 4'd0,  32'h0,  32'h0, 32'h0,  16'h0002, 4'd1, 1);
    vt[7]  = mk(1, 4'd2,  0, 32'h22, 1, 0, 0, 4'd0,  32'h0,  32'h0, 32'h0,  16'h0006, 4'd2, 1);
    vt[8]  = mk(1, 4'd5,  0, 32'h55, 1, 0, 0, 4'd0,  32'h0,  32'h0, 32'h0,  16'h0026, 4'd3, 1);
    vt[9]  = mk(1, 4'd6,  0, 32'h66, 1, 0, 0, 4'd0,  32'h0,  32'h0, 32'h0,  16'h0066, 4'd4, 0);
    vt[10] = mk(1, 4'd7,  0, 32'h77, 1, 0, 0, 4'd0,  32'h0,  32'h0, 32'h0,  16'h0066, 4'd4, 0);
    vt[11] = mk(0, 4'd0,  0, 32'h0,  0, 1, 0, 4'd1,  32'h11, 32'h0, 32'h0,  16'h0066, 4'd3, 1);
    vt[12] = mk(0, 4'd0,  0, 32'h0,  0, 1, 0, 4'd2,  32'h22, 32'h0, 32'h0,  16'h0064, 4'd2, 1);
    vt[13] = mk(0, 4'd0,  0, 32'h0,  0, 1, 0, 4'd5,  32'h55, 32'h0, 32'h0,  16'h0060, 4'd1, 1);
    vt[14] = mk(0, 4'd0,  0, 32'h0,  0, 1, 0, 4'd6,  32'h66, 32'h0, 32'h0,  16'h0040, 4'd0, 1);
    vt[15] = mk(0, 4'd0,  0, 32'h0,  0, 0, 0, 4'd0,  32'h0,  32'h0, 32'h0,  16'h0000, 4'd0, 1);
    vt[16] = mk(1, 4'd4,  0, 32'h9,  0, 0, 0, 4'd0,  32'h0,  32'h0, 32'h0,  16'h0010, 4'd1, 1);
    vt[17] = mk(1, 4'd4,  0, 32'hB,  0, 1, 0, 4'd4,  32'h9,  32'h0, 32'h0,  16'h0010, 4'd1, 1);
    vt[18] = mk(0, 4'd0,  0, 32'h0,  0, 1, 0, 4'd4,  32'hB,  32'h0, 32'h0,  16'h0010, 4'd0, 1);
    vt[19] = mk(0, 4'd0,  0, 32'h0,  0, 0, 0, 4'd0,  32'h0,  32'h0, 32'h0,  16'h0000, 4'd0, 1);

    RESET  = 1'b0;
    rd_sel = 12'hABC;
    drive(0, 4'd0, 0, 32'h0, 0, 0);

    // Reset state
    #12;
    chk("rst_ready",  {63'b0, req_ready}, 64'd0);
    chk("rst_load",   {63'b0, rf_LOAD},   64'd0);
    chk("rst_loadpc", {63'b0, rf_LOADPC}, 64'd0);
    chk("rst_ircu",   {63'b0, rf_IR_CU},  64'd0);
    chk("rst_rd",     {32'b0, rf_Rd},     64'd0);
    chk("rst_mem",    {32'b0, rf_Mem},    64'd0);
    chk("rst_pcin",   {32'b0, rf_Pcin},   64'd0);
    chk("rst_rslct",  {60'b0, rf_RSLCT[3:0]}, 64'd0);
    chk("rst_pend",   {48'b0, pend_mask}, 64'd0);
    chk("rst_qcount", {60'b0, q_count},   64'd0);
    chk("rst_fwdhit", {61'b0, fwd_hit},   64'd0);
    chk("rst_fwddata_lo", fwd_data[63:0], 64'd0);
    @(negedge Clk);
    RESET = 1'b1;
    tick();
    chk("rst_ready_after", {63'b0, req_ready}, 64'd1);

    for (int i = 0; i < 20; i++) begin
      drive(vt[i].v, vt[i].dest, vt[i].src, vt[i].data, vt[i].stall, 0);
      tick();
      chk($sformatf("v%0d_load", i),   {63'b0, rf_LOAD},   {63'b0, vt[i].ld});
      chk($sformatf("v%0d_loadpc", i), {63'b0, rf_LOADPC}, {63'b0, vt[i].lpc});
      chk($sformatf("v%0d_ircu", i),   {63'b0, rf_IR_CU},  {63'b0, vt[i].ld | vt[i].lpc});
      chk($sformatf("v%0d_rslct", i),  {60'b0, rf_RSLCT[3:0]}, {60'b0, vt[i].rsl});
      chk($sformatf("v%0d_rslct_hi", i), {48'b0, rf_RSLCT[19:4]}, 64'h0ABC);
      chk($sformatf("v%0d_rd", i),     {32'b0, rf_Rd},     {32'b0, vt[i].rd});
      chk($sformatf("v%0d_mem", i),    {32'b0, rf_Mem},    {32'b0, vt[i].mem});
      chk($sformatf("v%0d_pcin", i),   {32'b0, rf_Pcin},   {32'b0, vt[i].pc});
      chk($sformatf("v%0d_pend", i),   {48'b0, pend_mask}, {48'b0, vt[i].pend});
      chk($sformatf("v%0d_qcount", i), {60'b0, q_count},   {60'b0, vt[i].qc});
      chk($sformatf("v%0d_ready", i),  {63'b0, req_ready}, {63'b0, vt[i].rdy});
    end

    // Reset asserted while a write is on the bus
    drive(1, 4'd2, 0, 32'h1, 0, 0);
    tick();
    drive(0, 4'd0, 0, 32'h0, 0, 0);
    tick();
    chk("rmid_load_issue", {63'b0, rf_LOAD}, 64'd1);
    #2;
    RESET = 1'b0;
    #1;
    chk("rmid_load_async", {63'b0, rf_LOAD},  64'd0);
    chk("rmid_ircu_async", {63'b0, rf_IR_CU}, 64'd0);
    chk("rmid_rd_async",   {32'b0, rf_Rd},    64'd0);
    chk("rmid_ready_low",  {63'b0, req_ready}, 64'd0);
    @(negedge Clk);
    RESET = 1'b1;
    tick();
    chk("rmid_pend",   {48'b0, pend_mask}, 64'd0);
    chk("rmid_qcount", {60'b0, q_count},   64'd0);
    chk("rmid_ready",  {63'b0, req_ready}, 64'd1);

    // Flush while dest 1 is issuing
    drive(1, 4'd1, 0, 32'hA1, 1, 0); tick();
    drive(1, 4'd2, 0, 32'hA2, 1, 0); tick();
    drive(1, 4'd3, 0, 32'hA3, 1, 0); tick();
    chk("fl_qcount_3", {60'b0, q_count},   64'd3);
    chk("fl_pend_3",   {48'b0, pend_mask}, 64'h000E);
    drive(0, 4'd0, 0, 32'h0, 0, 0); tick();
    chk("fl_issue_load", {63'b0, rf_LOAD}, 64'd1);
    chk("fl_issue_dest", {60'b0, rf_RSLCT[3:0]}, 64'd1);
    chk("fl_issue_rd",   {32'b0, rf_Rd}, 64'hA1);
    drive(1, 4'd9, 0, 32'hDEAD, 0, 1); tick();
    chk("fl_qcount", {60'b0, q_count},   64'd0);
    chk("fl_pend",   {48'b0, pend_mask}, 64'd0);
    chk("fl_ready",  {63'b0, req_ready}, 64'd1);
    drive(0, 4'd0, 0, 32'h0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("fl_post%0d_load", c), {63'b0, rf_LOAD}, 64'd0);
      tick();
      chk($sformatf("fl_post%0d_pend", c), {48'b0, pend_mask}, 64'd0);
    end

    // Forwarding: Rn=4 matches twice, Rm=5 never matches
    rd_sel = 12'h054;
    drive(1, 4'd4, 0, 32'h9, 1, 0); tick();
    drive(1, 4'd4, 0, 32'hB, 1, 0); tick();
    drive(0, 4'd0, 0, 32'h0, 1, 0);
    #1;
    chk("byp_hit_q",  {61'b0, fwd_hit},        {61'b0, 2'b00, C_BYP});
    chk("byp_rn_q",   {32'b0, fwd_data[31:0]},  C_BYP ? 64'hB : 64'h0);
    chk("byp_rm_q",   {32'b0, fwd_data[63:32]}, 64'h0);
    drive(0, 4'd0, 0, 32'h0, 0, 0); tick();
    chk("byp_rd_first", {32'b0, rf_Rd}, 64'h9);
    chk("byp_hit_mix",  {61'b0, fwd_hit},       {61'b0, 2'b00, C_BYP});
    chk("byp_rn_mix",   {32'b0, fwd_data[31:0]}, C_BYP ? 64'hB : 64'h0);
    tick();
    chk("byp_rd_second", {32'b0, rf_Rd}, 64'hB);
    chk("byp_hit_iss",   {61'b0, fwd_hit},       {61'b0, 2'b00, C_BYP});
    chk("byp_rn_iss",    {32'b0, fwd_data[31:0]}, C_BYP ? 64'hB : 64'h0);
    tick();
    chk("byp_hit_idle",  {61'b0, fwd_hit},       64'd0);
    chk("byp_rn_idle",   {32'b0, fwd_data[31:0]}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
